alu_op_sequencer: RTL and testbench

//   Command-driven issuer for the 32-bit combinational ALU. Accepts ALU commands

---
 rtl/alu_op_sequencer.sv | 111 +++++++++++
 tb/tb_alu_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the combinational 32-bit ALU: owns an 8-entry register file,
// issues registered operands to the ALU, writes results back and returns them.
//   state  | meaning
//   S_IDLE | accepting loads and commands
//   S_EXEC | operands on the ALU, result captured at the closing edge
//   S_RESP | response held until rsp_ready
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int AW     = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_rs1,
  input  logic [AW-1:0]     cmd_rs2,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int NREGS = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rf [NREGS];
  logic [AW-1:0]     rd_q;
  logic              cmd_fire;
  logic              load_fire;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign load_fire = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    load_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready  = 1'b1;
        load_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_op[3] ? S_RESP : S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Loads and command operand reads share the IDLE edge; the command sees pre-load values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      rd_q        <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_control <= 4'b0000;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      ops_done    <= '0;
    end else begin
      if (load_fire) rf[load_addr] <= load_data;
      if (cmd_fire) begin
        if (!cmd_op[3]) begin
          alu_op1     <= rf[cmd_rs1];
          alu_op2     <= rf[cmd_rs2];
          alu_control <= cmd_op;
          rd_q        <= cmd_rd;
        end else begin
          rsp_err  <= 1'b1;
          rsp_data <= '0;
          rsp_zero <= 1'b0;
        end
      end
      if (state == S_EXEC) begin
        rf[rd_q] <= alu_result;
        rsp_data <= alu_result;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
        ops_done <= ops_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and register-file model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [2:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [31:0] alu_op1, alu_op2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mrf [8];
  int          mcnt;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return ~a;
      4'd1: return a & b;
      4'd2: return a ^ b;
      4'd3: return a | b;
      4'd4: return a - 32'd1;
      4'd5: return a + b;
      4'd6: return a - b;
      4'd7: return a + 32'd1;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stand-in for the real ALU instance.
  always_comb begin
    alu_result = alu_fn(alu_control, alu_op1, alu_op2);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    mcnt = 0;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ld_en, input logic [2:0] ld_a,
                        input logic [31:0] ld_d, input int rdy_delay,
                        output logic [31:0] d, output logic z, output logic e, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    load_valid = ld_en; load_addr = ld_a; load_data = ld_d;
    @(negedge clk);
    cmd_valid = 1'b0; load_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout got rsp_valid=%b after %0d cycles exp 1", rsp_valid, lat);
      d = 'x; z = 1'bx; e = 1'bx;
      return;
    end
    d = rsp_data; z = rsp_zero; e = rsp_err;
    repeat (rdy_delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    mcnt = 0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {rsp_valid, rsp_err, rsp_zero});
    end
    checks++;
    if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops got %0d exp 0", ops_done); end
    checks++;
    if ({alu_control, alu_op1, alu_op2, rsp_data} !== '0) begin
      errors++; $display("FAIL reset_regs got ctl=%h op1=%h op2=%h data=%h exp 0", alu_control, alu_op1, alu_op2, rsp_data);
    end
    checks++;
    if ({cmd_ready, load_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b exp 11", {cmd_ready, load_ready});
    end
  endtask

  task automatic test_logic();
    logic [31:0] d; logic z, e; int lat;
    do_load(3'd1, 32'hAAAA5555);
    do_load(3'd2, 32'hFFFF0000);
    do_cmd(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
    checks++;
    if ({d, z, e} !== {32'hAAAA0000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL and_rsp got %h z=%b e=%b exp aaaa0000 z=0 e=0", d, z, e);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL legal_latency got %0d exp 2", lat); end
    do_cmd(4'd3, 3'd4, 3'd3, 3'd2, 1'b0, 3'd0, 32'd0, 1, d, z, e, lat);
    checks++;
    if (d !== 32'hFFFF0000) begin errors++; $display("FAIL or_dep got %h exp ffff0000", d); end
  endtask

  task automatic test_arith();
    logic [31:0] d; logic z, e; int lat;
    logic [3:0]  ops [5] = '{4'd5, 4'd6, 4'd7, 4'd2, 4'd0};
    logic [2:0]  s1  [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
    logic [31:0] exp [5] = '{32'h100, 32'hFE, 32'h100, 32'hFE, 32'hFFFFFFFE};
    logic [15:0] base;
    do_reset();
    base = ops_done;
    do_load(3'd1, 32'h000000FF);
    do_load(3'd2, 32'h00000001);
    for (int i = 0; i < 5; i++) begin
      do_cmd(ops[i], 3'(i + 3), s1[i], 3'd2, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
      checks++;
      if (d !== exp[i] || z !== 1'b0 || e !== 1'b0) begin
        errors++; $display("FAIL arith_op%0d got %h z=%b e=%b exp %h", ops[i], d, z, e, exp[i]);
      end
    end
    checks++;
    if (ops_done !== base + 16'd5 || ops_done !== 16'd5) begin
      errors++; $display("FAIL arith_count got %0d exp 5", ops_done);
    end
  endtask

  task automatic test_dec_zero();
    logic [31:0] d; logic z, e; int lat;
    do_load(3'd5, 32'h1);
    do_cmd(4'd4, 3'd5, 3'd5, 3'd0, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
    checks++;
    if (d !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL dec_zero got %h z=%b exp 0 z=1", d, z); end
    do_cmd(4'd4, 3'd5, 3'd5, 3'd0, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
    checks++;
    if (d !== 32'hFFFFFFFF || z !== 1'b0) begin errors++; $display("FAIL dec_wrap got %h z=%b exp ffffffff z=0", d, z); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic z, e; int lat;
    logic [3:0]  ctl0; logic [31:0] op10; logic [15:0] cnt0;
    ctl0 = alu_control; op10 = alu_op1; cnt0 = ops_done;
    do_cmd(4'b1000, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 32'd0, 2, d, z, e, lat);
    checks++;
    if ({d, z, e} !== {32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL illegal_rsp got %h z=%b e=%b exp 0 z=0 e=1", d, z, e);
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d exp 1", lat); end
    checks++;
    if (ops_done !== cnt0) begin errors++; $display("FAIL illegal_count got %0d exp %0d", ops_done, cnt0); end
    checks++;
    if (alu_control !== ctl0 || alu_op1 !== op10) begin
      errors++; $display("FAIL illegal_alu_hold got ctl=%h op1=%h exp ctl=%h op1=%h", alu_control, alu_op1, ctl0, op10);
    end
    do_cmd(4'd3, 3'd5, 3'd5, 3'd5, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
    checks++;
    if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL illegal_no_wb got %h exp ffffffff", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic z, e; int lat;
    do_load(3'd1, 32'h12345678);
    do_load(3'd2, 32'h11111111);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_rd = 3'd6; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    load_valid = 1'b1; load_addr = 3'd1; load_data = 32'hBAD0BAD0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, load_ready} !== 3'b100 || rsp_data !== 32'h23456789) begin
        errors++; $display("FAIL stall_cycle%0d got v=%b cr=%b lr=%b d=%h exp v=1 cr=0 lr=0 d=23456789",
                           i, rsp_valid, cmd_ready, load_ready, rsp_data);
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h23456789) begin
      errors++; $display("FAIL after_hs got v=%b d=%h exp v=0 d=23456789", rsp_valid, rsp_data);
    end
    do_cmd(4'd3, 3'd7, 3'd1, 3'd1, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL stall_no_load got %h exp 12345678", d); end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] d; logic z, e; int lat;
    do_load(3'd1, 32'd5);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01 || ops_done !== 16'd0 || alu_control !== 4'd0) begin
      errors++; $display("FAIL midexec_reset got v=%b cr=%b ops=%0d ctl=%h exp v=0 cr=1 ops=0 ctl=0",
                         rsp_valid, cmd_ready, ops_done, alu_control);
    end
    for (int i = 0; i < 8; i++) begin
      do_cmd(4'd3, 3'(i), 3'(i), 3'(i), 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL rf_cleared r%0d got %h exp 0", i, d); end
    end
    do_load(3'd1, 32'd5);
    do_cmd(4'd5, 3'd2, 3'd1, 3'd1, 1'b1, 3'd1, 32'd7, 0, d, z, e, lat);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL same_cycle_old got %h exp 0000000a", d); end
    do_cmd(4'd3, 3'd3, 3'd1, 3'd1, 1'b0, 3'd0, 32'd0, 0, d, z, e, lat);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL same_cycle_commit got %h exp 00000007", d); end
  endtask

  task automatic test_random();
    logic [31:0] d; logic z, e; int lat;
    logic [3:0]  op; logic [2:0] rd, rs1, rs2, la; logic [31:0] ld, res; logic ld_en;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ld = $urandom;
      if ($urandom_range(0, 3) == 0) ld = 32'd0;
      do_load(3'(i), ld);
      mrf[i] = ld;
    end
    for (int n = 0; n < 60; n++) begin
      op  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rd  = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = 3'($urandom_range(0, 7));
      ld_en = ($urandom_range(0, 3) == 0);
      la  = 3'($urandom_range(0, 7));
      ld  = $urandom;
      do_cmd(op, rd, rs1, rs2, ld_en, la, ld, $urandom_range(0, 3), d, z, e, lat);
      res = (op >= 4'd8) ? 32'd0 : alu_fn(op, mrf[rs1], mrf[rs2]);
      if (ld_en) mrf[la] = ld;
      if (op < 4'd8) begin
        mrf[rd] = res;
        mcnt++;
      end
      checks++;
      if (d !== res || z !== (op < 4'd8 && res == 32'd0) || e !== (op >= 4'd8) || lat !== ((op >= 4'd8) ? 1 : 2)) begin
        errors++; $display("FAIL random%0d op=%0d got %h z=%b e=%b lat=%0d exp %h", n, op, d, z, e, lat, res);
      end
      checks++;
      if (ops_done !== 16'(mcnt)) begin errors++; $display("FAIL random_count%0d got %0d exp %0d", n, ops_done, mcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_dec_zero();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
